// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - machine-external interrupt controller with claim/complete flow
//
// Optional feature macro: EXT_IRQ_CTRL_EDGE_EN (per-source edge triggering via EDGE_CFG).
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   irq_src_i    asynchronous request lines, bit 0 highest priority
//   irq_ack_i    one-cycle acknowledge from the core
//   meip_o       registered interrupt request to the core
//   reg_we_i     register write strobe
//   reg_addr_i   word address (0 PENDING, 1 ENABLE, 2 CLAIM, 3 COMPLETE, 4 EDGE_CFG)
//   reg_wdata_i  write data
//   reg_rdata_o  registered read data (1-cycle latency)
module ext_irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_SRC-1:0]  irq_src_i,
  input  logic              irq_ack_i,
  output logic              meip_o,
  input  logic              reg_we_i,
  input  logic [2:0]        reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic [31:0]       reg_rdata_o
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  sync_q [SYNC_STAGES];
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  enable_q;
  logic [N_SRC-1:0]  in_service_q, in_service_d;
  logic [4:0]        claim_id_q, claim_id_d;
  logic              meip_q;
  logic [31:0]       rdata_q, rdata_d;

  logic [N_SRC-1:0]  s;
  logic [N_SRC-1:0]  set_vec;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  winner_oh;
  logic [4:0]        winner;
  logic              claim;
  logic              complete;

  // Only the low bits of the write bus carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata_i;

  assign s        = sync_q[SYNC_STAGES-1];
  assign eligible = pending_q & enable_q;

`ifdef EXT_IRQ_CTRL_EDGE_EN
  logic [N_SRC-1:0] edge_cfg_q;
  logic [N_SRC-1:0] hist_q;

  // Edge sources pend on a rising synchronised edge even while in service,
  // so an edge arriving during service is not lost.
  assign set_vec = (edge_cfg_q & s & ~hist_q) | (~edge_cfg_q & s & ~in_service_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      edge_cfg_q <= '0;
      hist_q     <= '0;
    end else begin
      hist_q <= s;
      if (reg_we_i && reg_addr_i == 3'd4) edge_cfg_q <= reg_wdata_i[N_SRC-1:0];
    end
  end
`else
  assign set_vec = s & ~in_service_q;
`endif

  // Lowest-index eligible source wins: scan high to low so the last hit sticks.
  always_comb begin
    winner    = '0;
    winner_oh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner    = 5'(i);
        winner_oh = '0;
        winner_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    claim    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: if (eligible != '0) state_d = REQ;
      REQ: begin
        if (eligible == '0) begin
          state_d = IDLE;
        end else if (irq_ack_i) begin
          claim   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (reg_we_i && reg_addr_i == 3'd3 && reg_wdata_i[4:0] == claim_id_q) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A claim clearing the winner beats a same-cycle set of that bit.
  always_comb begin
    pending_d    = (pending_q | set_vec) & ~(claim ? winner_oh : '0);
    in_service_d = in_service_q;
    claim_id_d   = claim_id_q;
    if (claim) begin
      in_service_d = winner_oh;
      claim_id_d   = winner + 5'd1;
    end else if (complete) begin
      in_service_d = '0;
      claim_id_d   = '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_addr_i)
      3'd0: rdata_d[N_SRC-1:0] = pending_q;
      3'd1: rdata_d[N_SRC-1:0] = enable_q;
      3'd2: rdata_d[4:0]       = claim_id_q;
`ifdef EXT_IRQ_CTRL_EDGE_EN
      3'd4: rdata_d[N_SRC-1:0] = edge_cfg_q;
`endif
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      in_service_q <= '0;
      claim_id_q   <= '0;
      meip_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q   <= state_d;
      sync_q[0] <= irq_src_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      claim_id_q   <= claim_id_d;
      meip_q       <= (state_d == REQ);
      rdata_q      <= rdata_d;
      if (reg_we_i && reg_addr_i == 3'd1) enable_q <= reg_wdata_i[N_SRC-1:0];
    end
  end

  assign meip_o      = meip_q;
  assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb/tb_ext_irq_ctrl.sv - directed self-checking bench for ext_irq_ctrl
module tb_ext_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  irq_src_i = '0;
  logic        irq_ack_i = 1'b0;
  logic        meip_o;
  logic        reg_we_i = 1'b0;
  logic [2:0]  reg_addr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [31:0] reg_rdata_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rv;

  ext_irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .irq_src_i   (irq_src_i),
    .irq_ack_i   (irq_ack_i),
    .meip_o      (meip_o),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    tick();
    reg_we_i = 1'b0; reg_wdata_i = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    reg_addr_i = a;
    tick();
    d = reg_rdata_o;
  endtask

  task automatic ack();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset_i = 1'b0;
    check_eq("rst_meip", {31'b0, meip_o}, 32'h0);
    rd(3'd0, rv); check_eq("rst_pending", rv, 32'h0);
    rd(3'd1, rv); check_eq("rst_enable", rv, 32'h0);
    rd(3'd2, rv); check_eq("rst_claim", rv, 32'h0);

    // Single source latency: meip on the 4th edge after the source rises
    wr(3'd1, 32'h01);
    rd(3'd1, rv); check_eq("enable_rb", rv, 32'h01);
    irq_src_i = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq($sformatf("lat_meip_e%0d", i), {31'b0, meip_o}, (i == 4) ? 32'h1 : 32'h0);
    end
    irq_src_i = 8'h00;
    rd(3'd0, rv); check_eq("lat_pending", rv, 32'h01);
    ack();
    check_eq("ack0_meip", {31'b0, meip_o}, 32'h0);
    rd(3'd2, rv); check_eq("ack0_claim", rv, 32'h1);
    rd(3'd0, rv); check_eq("ack0_pending", rv, 32'h0);
    wr(3'd3, 32'h1);
    tick(); tick();
    check_eq("cmp0_idle_meip", {31'b0, meip_o}, 32'h0);
    rd(3'd2, rv); check_eq("cmp0_claim", rv, 32'h0);

    // Priority: sources 2 and 3 together
    wr(3'd1, 32'hFF);
    irq_src_i = 8'h0C;
    tick(); tick(); tick(); tick();
    check_eq("prio_meip", {31'b0, meip_o}, 32'h1);
    irq_src_i = 8'h00;
    rd(3'd0, rv); check_eq("prio_pending", rv, 32'h0C);
    ack();
    check_eq("prio_ack_meip", {31'b0, meip_o}, 32'h0);
    rd(3'd2, rv); check_eq("prio_claim", rv, 32'h3);
    rd(3'd0, rv); check_eq("prio_pending2", rv, 32'h08);
    wr(3'd3, 32'h3);
    check_eq("recmp_meip_e1", {31'b0, meip_o}, 32'h0);
    tick();
    check_eq("recmp_meip_e2", {31'b0, meip_o}, 32'h1);
    ack();
    rd(3'd2, rv); check_eq("claim4", rv, 32'h4);
    wr(3'd3, 32'h2);
    tick(); tick();
    check_eq("badcmp_meip", {31'b0, meip_o}, 32'h0);
    rd(3'd2, rv); check_eq("badcmp_claim", rv, 32'h4);
    rd(3'd6, rv); check_eq("reserved_rd", rv, 32'h0);
    rd(3'd3, rv); check_eq("complete_rd", rv, 32'h0);

    // Reset while BUSY
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_eq("busyrst_meip", {31'b0, meip_o}, 32'h0);
    rd(3'd2, rv); check_eq("busyrst_claim", rv, 32'h0);
    rd(3'd1, rv); check_eq("busyrst_enable", rv, 32'h0);
    rd(3'd0, rv); check_eq("busyrst_pending", rv, 32'h0);

    // Level source held high through claim and complete
    wr(3'd1, 32'h01);
    irq_src_i = 8'h01;
    tick(); tick(); tick(); tick();
    check_eq("lvl_meip", {31'b0, meip_o}, 32'h1);
    wr(3'd1, 32'h00);
    tick();
    check_eq("lvl_disable_meip", {31'b0, meip_o}, 32'h0);
    wr(3'd1, 32'h01);
    tick();
    check_eq("lvl_reenable_meip", {31'b0, meip_o}, 32'h1);
    ack();
    rd(3'd2, rv); check_eq("lvl_claim", rv, 32'h1);
    tick(); tick();
    rd(3'd0, rv); check_eq("lvl_no_repend", rv, 32'h0);
    wr(3'd3, 32'h1);
    rd(3'd0, rv); check_eq("lvl_pend_e2", rv, 32'h0);
    rd(3'd0, rv); check_eq("lvl_pend_e3", rv, 32'h1);
    check_eq("lvl_remeip", {31'b0, meip_o}, 32'h1);
    irq_src_i = 8'h00;
    tick(); tick();
    ack();
    tick(); tick();
    wr(3'd3, 32'h1);
    tick(); tick();
    rd(3'd0, rv); check_eq("lvl_drained", rv, 32'h0);

`ifdef EXT_IRQ_CTRL_EDGE_EN
    // Edge source pulsed twice while in service re-pends exactly once
    wr(3'd4, 32'h02);
    wr(3'd1, 32'h02);
    rd(3'd4, rv); check_eq("edge_cfg_rb", rv, 32'h02);
    irq_src_i = 8'h02; tick(); irq_src_i = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    check_eq("edge_meip", {31'b0, meip_o}, 32'h1);
    ack();
    rd(3'd2, rv); check_eq("edge_claim", rv, 32'h2);
    for (int p = 0; p < 2; p++) begin
      irq_src_i = 8'h02; tick(); irq_src_i = 8'h00;
      tick(); tick(); tick();
    end
    rd(3'd0, rv); check_eq("edge_inservice_pend", rv, 32'h02);
    wr(3'd3, 32'h2);
    tick();
    check_eq("edge_remeip", {31'b0, meip_o}, 32'h1);
    ack();
    rd(3'd2, rv); check_eq("edge_claim2", rv, 32'h2);
    wr(3'd3, 32'h2);
    tick(); tick(); tick();
    check_eq("edge_once_meip", {31'b0, meip_o}, 32'h0);
`else
    wr(3'd4, 32'hFF);
    rd(3'd4, rv); check_eq("edgecfg_absent", rv, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- Machine-external interrupt controller sitting directly upstream of barebones_top.
- Collects N_SRC peripheral interrupt lines, synchronises and latches them as pending bits, and masks them with an enable register.
- Drives the core's meip_i from its meip_o, consumes the core's irq_ack_o on irq_ack_i, and exposes claim/complete registers on a simple word-addressed bus.
- Replaces the ad-hoc "clear meip on ack" behaviour with a proper claim/in-service/complete flow.

Parameters:
- N_SRC, 8, number of interrupt sources; legal range 1..31.
- SYNC_STAGES, 2, flops in each per-source input synchroniser; minimum 2.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- irq_src_i  input  N_SRC  asynchronous interrupt request lines; bit 0 has the highest priority.
- irq_ack_i  input  1  single-cycle pulse from the core (irq_ack_o) when it takes the interrupt.
- meip_o  output  1  machine external interrupt request to the core (meip_i).
- reg_we_i  input  1  register write strobe.
- reg_addr_i  input  3  word address.
- reg_wdata_i  input  32  write data.
- reg_rdata_o  output  32  read data, registered.

Behaviour:
- Reset values:
  - meip_o=0, reg_rdata_o=0.
  - PENDING, ENABLE, IN_SERVICE, CLAIM_ID all 0.
  - Synchroniser flops 0; FSM in IDLE.
- Register map (unlisted bits read 0, writes to them are ignored):
  - 0 PENDING: read-only.
  - 1 ENABLE: read/write, N_SRC bits.
  - 2 CLAIM: read-only; returns claimed source id+1, or 0 if nothing is claimed.
  - 3 COMPLETE: write-only; reads 0.
  - 4 EDGE_CFG: see Optional Feature.
  - 5-7: reserved; read 0, writes ignored.
- Read path: reg_rdata_o <= mux(reg_addr_i) every cycle, giving 1-cycle read latency.
- Pending logic, per source i:
  - Sync output s[i] is the final synchroniser stage.
  - Level mode: pending[i] is set when s[i]=1 and in_service[i]=0.
  - Pending stays latched even if the source drops; it is cleared only by a claim.
  - If set and clear of pending[i] occur in the same cycle, clear wins.
- Eligible vector: pending & enable. The winner is the lowest-index eligible bit, computed combinationally.
- FSM states and transitions:
  - IDLE: if eligible != 0, go to REQ.
  - REQ:
    - meip_o=1 (registered, so it rises on the edge that enters REQ).
    - If eligible becomes 0 (enable cleared), go to IDLE and meip_o falls on that edge.
    - On irq_ack_i: CLAIM_ID <= winner+1; pending[winner] <= 0; in_service[winner] <= 1; go to BUSY. meip_o falls on the same edge.
  - BUSY:
    - meip_o=0; pending keeps accumulating.
    - A write to COMPLETE with reg_wdata_i[4:0]==CLAIM_ID clears in_service and CLAIM_ID and goes to IDLE.
    - A write with a mismatched id is ignored and the FSM stays in BUSY.
- irq_ack_i in IDLE or BUSY is ignored.
- Latency: a source rising with an enabled, idle controller gives pending at edge SYNC_STAGES+1 and meip_o=1 at edge SYNC_STAGES+2 (4 cycles with the defaults).
- After complete with another source still eligible: IDLE→REQ takes one edge, so meip_o re-asserts 2 edges after the COMPLETE write.
- Only one source is in service at a time; there is no nesting.
- reset_i mid-operation returns every register and the FSM to reset values on the next edge, including an in-flight claim.

Optional Feature:
- Macro: EXT_IRQ_CTRL_EDGE_EN.
- When defined:
  - EDGE_CFG (addr 4) is an N_SRC-bit read/write register, reset 0.
  - A bit set to 1 makes that source edge-triggered: pending[i] is set on a 0→1 transition of s[i], using an extra history flop.
  - An edge arriving while in_service[i]=1 still sets pending[i], so that edge is not lost.
  - Level sources behave as described in Behaviour.
- When undefined:
  - All sources are level-triggered.
  - Address 4 reads 0 and writes to it are ignored.
  - No history flops are synthesised.

Test Plan:
- Reset, then ENABLE=0x01, then irq_src_i[0]=1 → meip_o=1 exactly 4 cycles later; a read of PENDING returns 0x01.
- ENABLE=0xFF, then irq_src_i=0x0C together, then pulse irq_ack_i → meip_o falls; CLAIM reads 3; PENDING=0x08.
- Write COMPLETE=3 → meip_o=1 again 2 cycles later; ack → CLAIM reads 4. COMPLETE=2 while CLAIM=4 → ignored, FSM stays BUSY, meip_o stays 0.
- Level source 0 held high through claim and complete → no re-pend while in service; pending re-sets the cycle after COMPLETE=1.
- With EXT_IRQ_CTRL_EDGE_EN: EDGE_CFG=0x02, pulse source 1 twice while it is in service → after COMPLETE=2, meip_o re-asserts once and CLAIM=2 after the next ack.
- Assert reset_i while in BUSY → next edge: meip_o=0, CLAIM=0, ENABLE=0, PENDING=0.
